cmsdk_mcu_mtx4x2_in_s2: RTL

CMSDK_MCU_MTX4X2_IN_S2 -- requirements
Module: cmsdk_mcu_mtx4x2_in_S2

---
 rtl/cmsdk_mcu_mtx4x2_in_s2.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cmsdk_mcu_mtx4x2_in_s2.sv
// Input stage for one slave port of a 4x2 AHB matrix: it holds a transfer the decoder cannot take yet.
// Optional HAUSERS capture is enabled by defining MTX4X2_IN_AUSER_EN.
module cmsdk_mcu_mtx4x2_in_s2 (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [2:0]  HAUSERS,
  input  logic        HREADYS,
  output logic        sel_in,
  output logic [31:0] addr_in,
  output logic [1:0]  trans_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [2:0]  burst_in,
  output logic [3:0]  prot_in,
  output logic [2:0]  auser_in,
  output logic        held_tran_in,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic [1:0]  resp_dec,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } pend_t;

  pend_t       r_pend_tran;
  pend_t       w_pend_next;
  logic        w_trans_req;

  logic        r_sel;
  logic [31:0] r_addr;
  logic [1:0]  r_trans;
  logic        r_write;
  logic [2:0]  r_size;
  logic [2:0]  r_burst;
  logic [3:0]  r_prot;
`ifdef MTX4X2_IN_AUSER_EN
  logic [2:0]  r_auser;
`else
  logic        w_unused_auser;
  assign w_unused_auser = ^HAUSERS;
`endif

  assign w_trans_req = HSELS & HTRANSS[1] & HREADYS;

  // Snapshot the address phase on every completed bus cycle, so the register
  // always carries the most recent address phase when the FSM decides to hold.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_trans <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
`ifdef MTX4X2_IN_AUSER_EN
      r_auser <= '0;
`endif
    end else if (HREADYS) begin
      r_sel   <= HSELS;
      r_addr  <= HADDRS;
      r_trans <= HTRANSS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_burst <= HBURSTS;
      r_prot  <= HPROTS;
`ifdef MTX4X2_IN_AUSER_EN
      r_auser <= HAUSERS;
`endif
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend_tran <= EMPTY;
    end else begin
      r_pend_tran <= w_pend_next;
    end
  end

  always_comb begin
    w_pend_next = r_pend_tran;
    unique case (r_pend_tran)
      EMPTY: if (w_trans_req && !active_dec) w_pend_next = HELD;
      HELD:  if (active_dec && readyout_dec) w_pend_next = EMPTY;
      default: w_pend_next = EMPTY;
    endcase
  end

  always_comb begin
    sel_in     = HSELS;
    addr_in    = HADDRS;
    trans_in   = HTRANSS;
    write_in   = HWRITES;
    size_in    = HSIZES;
    burst_in   = HBURSTS;
    prot_in    = HPROTS;
`ifdef MTX4X2_IN_AUSER_EN
    auser_in   = HAUSERS;
`else
    auser_in   = '0;
`endif
    HREADYOUTS = readyout_dec;
    HRESPS     = resp_dec;
    if (r_pend_tran == HELD) begin
      sel_in     = 1'b1;
      addr_in    = r_addr;
      // The held beat reaches the slave detached from its burst, so a SEQ
      // must be re-issued as NONSEQ.
      trans_in   = (r_trans == 2'b11) ? 2'b10 : r_trans;
      write_in   = r_write;
      size_in    = r_size;
      burst_in   = r_burst;
      prot_in    = r_prot;
`ifdef MTX4X2_IN_AUSER_EN
      auser_in   = r_auser;
`endif
      HREADYOUTS = 1'b0;
      HRESPS     = 2'b00;
    end
  end

  assign held_tran_in = r_pend_tran;

  // r_sel is captured for completeness of the snapshot; in HELD sel_in is forced high.
  logic w_unused_sel;
  assign w_unused_sel = r_sel;

endmodule
